// File: rtl/gray_frame_sink_if.sv
// Pixel stream, read port and frame handoff bundle for gray_frame_sink.
//   master: upstream / reader side (drives pixels, read requests, release)
//   slave : the frame sink (drives read data and frame_ready)
// Signals:
//   pix_valid/pix_data/pix_sof  : incoming pixel stream, sof marks pixel 0
//   rd_en/rd_addr               : random-access read request into held frame
//   rd_data/rd_valid            : read response, one cycle after rd_en
//   frame_ready/frame_release   : held-frame handshake with the reader
interface gray_frame_sink_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_ready;
  logic              frame_release;

  modport master (
    output pix_valid, pix_data, pix_sof, rd_en, rd_addr, frame_release,
    input  rd_data, rd_valid, frame_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, rd_en, rd_addr, frame_release,
    output rd_data, rd_valid, frame_ready
  );
endinterface

// File: rtl/gray_frame_sink.sv
// gray_frame_sink: ping-pong frame buffer at the tail of the grayscale stream.
// One bank fills from the pixel stream while the other is held for a
// random-access reader. A completed frame is swapped in when the reader is
// idle (or releases in the same cycle); otherwise it is parked (HOLD) and
// further pixels are dropped with a sticky overflow flag.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   bus (slave)      : pixel stream, read port, frame_ready/frame_release
//   wr_col, wr_row   : position of the next pixel to be written (0 unless filling)
//   frame_count      : frames handed to the reader, wraps at 2^16
//   overflow         : sticky, pixels dropped while both banks were busy
//   sync_err         : sticky, sof seen mid-frame
//   frame_sum        : (GRAY_STATS_EN only) pixel sum of the frame last handed over
// Optional feature macro: GRAY_STATS_EN
module gray_frame_sink #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 148,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15
) (
  input  logic                clk,
  input  logic                reset,
  gray_frame_sink_if.slave    bus,
  output logic [7:0]          wr_col,
  output logic [7:0]          wr_row,
  output logic [15:0]         frame_count,
  output logic                overflow,
  output logic                sync_err
`ifdef GRAY_STATS_EN
  , output logic [23:0]       frame_sum
`endif
);
  localparam int SIZE   = IMG_WIDTH * IMG_HEIGHT;
  localparam int MEM_AW = ADDR_W + 1;

  typedef enum logic [1:0] {SYNC, FILL, HOLD} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] cnt;
  logic [7:0]        col, row;
  logic              wr_bank, rd_bank, frame_ready;

  logic              accept, sof_wr, last, swap, set_ovf, set_serr;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        cur_col, cur_row;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SYNC;
    else       state <= state_nx;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    if (accept) state_nx = FILL;
      FILL:    if (last) state_nx = swap ? SYNC : HOLD;
      HOLD:    if (bus.frame_release) state_nx = SYNC;
      default: state_nx = SYNC;
    endcase
  end

  // ---------------- FSM: outputs / control ----------------
  always_comb begin
    accept   = 1'b0;
    set_ovf  = 1'b0;
    set_serr = 1'b0;
    wr_col   = '0;
    wr_row   = '0;
    case (state)
      SYNC: accept = bus.pix_valid && bus.pix_sof;
      FILL: begin
        accept   = bus.pix_valid;
        set_serr = bus.pix_valid && bus.pix_sof && (cnt != '0);
        wr_col   = col;
        wr_row   = row;
      end
      HOLD:    set_ovf = bus.pix_valid;
      default: ;
    endcase
    // an accepted sof always restarts the frame at pixel 0
    sof_wr  = accept && bus.pix_sof;
    idx     = sof_wr ? '0 : cnt;
    cur_col = sof_wr ? '0 : col;
    cur_row = sof_wr ? '0 : row;
    last    = accept && (idx == ADDR_W'(SIZE - 1));
    // release in the same cycle as completion frees the read bank first
    swap    = (last && (!frame_ready || bus.frame_release)) ||
              (state == HOLD && bus.frame_release);
  end

  // ---------------- counters, banks, flags ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt         <= '0;
      col         <= '0;
      row         <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (set_ovf)  overflow <= 1'b1;
      if (set_serr) sync_err <= 1'b1;
      if (last) begin
        cnt <= '0;
        col <= '0;
        row <= '0;
      end else if (accept) begin
        cnt <= idx + 1'b1;
        if (cur_col == 8'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= cur_row + 8'd1;
        end else begin
          col <= cur_col + 8'd1;
          row <= cur_row;
        end
      end
      if (swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (bus.frame_release) begin
        frame_ready <= 1'b0;
      end
    end

  // ---------------- storage and read port ----------------
  logic [DATA_W-1:0] mem [0:2*SIZE-1];
  logic [DATA_W-1:0] mem_q;
  logic [MEM_AW-1:0] wr_ptr, rd_ptr;
  logic              rd_oob, rd_vld, oob_q;

  assign rd_oob = bus.rd_addr >= ADDR_W'(SIZE);
  assign wr_ptr = {1'b0, idx}         + (wr_bank ? MEM_AW'(SIZE) : '0);
  assign rd_ptr = {1'b0, bus.rd_addr} + (rd_bank ? MEM_AW'(SIZE) : '0);

  always_ff @(posedge clk) begin
    if (accept)                  mem[wr_ptr] <= bus.pix_data;
    if (bus.rd_en && !rd_oob)    mem_q       <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_vld <= 1'b0;
      oob_q  <= 1'b0;
    end else begin
      rd_vld <= bus.rd_en;
      oob_q  <= rd_oob;
    end

  // out-of-range reads and idle cycles present zero
  assign bus.rd_data     = (rd_vld && !oob_q) ? mem_q : '0;
  assign bus.rd_valid    = rd_vld;
  assign bus.frame_ready = frame_ready;

`ifdef GRAY_STATS_EN
  logic [23:0] acc, acc_nx;

  assign acc_nx = sof_wr ? 24'(bus.pix_data) : acc + 24'(bus.pix_data);

  // a parked frame keeps its sum in acc until the release swaps it in
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      if (accept) acc <= acc_nx;
      if (swap)   frame_sum <= (state == HOLD) ? acc : acc_nx;
    end
`endif
endmodule

// File: tb/tb_gray_frame_sink.sv
// Randomized self-checking bench for gray_frame_sink with a frame-level
// reference model (pixel position, held frame, visible frame copy).
module tb_gray_frame_sink;
  localparam int W = 32, H = 12, SIZE = W * H, DW = 8, AW = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_frame_sink_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  logic [7:0]  wr_col, wr_row;
  logic [15:0] frame_count;
  logic        overflow, sync_err;
`ifdef GRAY_STATS_EN
  logic [23:0] frame_sum;
`endif

  gray_frame_sink #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .wr_col(wr_col), .wr_row(wr_row), .frame_count(frame_count),
    .overflow(overflow), .sync_err(sync_err)
`ifdef GRAY_STATS_EN
    , .frame_sum(frame_sum)
`endif
  );

  // ---------------- reference model ----------------
  int          pos;            // next pixel index of the frame in progress, -1 = waiting for sof
  bit          held;           // completed frame parked, waiting for release
  bit          m_ready, m_ovf, m_serr;
  int          m_count;
  logic [7:0]  cur   [SIZE];   // frame being assembled
  logic [7:0]  shown [SIZE];   // frame visible to the reader
  int unsigned acc, done_sum, m_sum;

  int n_pass, n_chk;
  int rel_rate;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    pos = -1; held = 0; m_ready = 0; m_ovf = 0; m_serr = 0;
    m_count = 0; acc = 0; done_sum = 0; m_sum = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit rel);
    bit done;
    done = 0;
    if (held) begin
      if (v) m_ovf = 1;
      if (rel) begin
        shown = cur; m_count++; m_sum = done_sum; held = 0;
      end
    end else begin
      if (v && s) begin
        if (pos > 0) m_serr = 1;
        pos = 0; acc = 0;
      end
      if (v && pos >= 0) begin
        cur[pos] = d; acc += d; pos++;
        if (pos == SIZE) begin done = 1; pos = -1; done_sum = acc; end
      end
      if (done && (!m_ready || rel)) begin
        shown = cur; m_ready = 1; m_count++; m_sum = done_sum;
      end else if (done) held = 1;
      else if (rel) m_ready = 0;
    end
  endtask

  // one clock: drive inputs, advance model, compare after the edge
  task automatic cyc(input bit v, input bit s, input logic [7:0] d, input bit rel,
                     input bit ren, input logic [AW-1:0] ra);
    bit         rd_known;
    logic [7:0] exp_rd, ecol, erow;
    bus.pix_valid = v; bus.pix_sof = s; bus.pix_data = d;
    bus.frame_release = rel; bus.rd_en = ren; bus.rd_addr = ra;
    rd_known = ren && (int'(ra) >= SIZE || m_ready);
    exp_rd   = (int'(ra) >= SIZE) ? 8'h00 : shown[int'(ra)];
    @(posedge clk);
    model_step(v, s, d, rel);
    #1;
    ecol = (!held && pos > 0) ? 8'(pos % W) : 8'h00;
    erow = (!held && pos > 0) ? 8'(pos / W) : 8'h00;
    chk("status", {frame_ready_o(), frame_count, overflow, sync_err, wr_col, wr_row},
        {m_ready, m_count[15:0], m_ovf, m_serr, ecol, erow});
    chk("rd_valid", bus.rd_valid, ren);
    if (rd_known) chk("rd_data", bus.rd_data, exp_rd);
`ifdef GRAY_STATS_EN
    chk("frame_sum", frame_sum, m_sum[23:0]);
`endif
  endtask

  function automatic logic frame_ready_o();
    return bus.frame_ready;
  endfunction

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit rel);
    bit ren;
    logic [AW-1:0] ra;
    ren = ($urandom % 3) == 0;
    ra  = (($urandom % 8) == 0) ? AW'($urandom_range(SIZE, 32767))
                                : AW'($urandom_range(0, SIZE - 1));
    cyc(v, s, d, rel, ren, ra);
  endtask

  // n pixels with random gaps; mode 0: data=idx, 1: random, 2: constant cval
  task automatic send_pix(input int n, input bit sof_first, input int mode,
                          input logic [7:0] cval, input int rel_at);
    logic [7:0] d;
    bit rel;
    for (int i = 0; i < n; i++) begin
      while (($urandom % 4) == 0) step(0, 0, 8'h00, 0);
      d   = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom) : cval;
      rel = (i == rel_at) || (rel_rate != 0 && ($urandom % rel_rate) == 0);
      step(1, sof_first && i == 0, d, rel);
    end
  endtask

  task automatic rd(input int a);
    cyc(0, 0, 8'h00, 0, 1, AW'(a));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_status"}, {bus.frame_ready, frame_count, overflow, sync_err, wr_col, wr_row}, '0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
`ifdef GRAY_STATS_EN
    chk({tag, "_frame_sum"}, frame_sum, 0);
`endif
  endtask

  initial begin
    n_pass = 0; n_chk = 0; rel_rate = 0;
    bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.frame_release = 0;
    reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    reset = 0;

    // 1: first frame, data = index
    send_pix(SIZE, 1, 0, 8'h00, -1);
    chk("t1_ready", bus.frame_ready, 1);
    chk("t1_count", frame_count, 1);
    rd(161);
    chk("t1_rd161", bus.rd_data, 8'hA1);
    chk("t1_rd161_v", bus.rd_valid, 1);
    rd(SIZE - 1);
    chk("t1_rdlast", bus.rd_data, 8'h7F);
    rd(SIZE);
    chk("t1_rd_oob", {bus.rd_valid, bus.rd_data}, 9'h100);

    // 2: frame 2 parks, frame 3 overflows, release swaps in frame 2
    send_pix(SIZE, 1, 1, 8'h00, -1);
    chk("t2_hold_ready", bus.frame_ready, 1);
    chk("t2_hold_count", frame_count, 1);
    chk("t2_no_ovf", overflow, 0);
    send_pix(20, 1, 1, 8'h00, -1);
    chk("t2_ovf", overflow, 1);
    cyc(0, 0, 8'h00, 1, 0, '0);
    chk("t2_rel_ready", bus.frame_ready, 1);
    chk("t2_rel_count", frame_count, 2);
    for (int a = 0; a < 8; a++) rd(a * 47);
    send_pix(30, 0, 1, 8'h00, -1);
    chk("t2_dropped_col", wr_col, 0);
    send_pix(SIZE, 1, 1, 8'h00, -1);
    cyc(0, 0, 8'h00, 1, 0, '0);
    cyc(0, 0, 8'h00, 1, 0, '0);
    chk("t2_released", bus.frame_ready, 0);

    // 3: resync at pixel 100
    send_pix(100, 1, 1, 8'h00, -1);
    chk("t3_no_serr", sync_err, 0);
    send_pix(1, 1, 1, 8'h00, -1);
    chk("t3_serr", sync_err, 1);
    chk("t3_col_row", {wr_col, wr_row}, {8'd1, 8'd0});
    send_pix(SIZE - 2, 0, 1, 8'h00, -1);
    chk("t3_not_done", bus.frame_ready, 0);
    send_pix(1, 0, 1, 8'h00, -1);
    chk("t3_done", bus.frame_ready, 1);

    // 4: release on the last pixel of the next frame -> direct swap
    send_pix(SIZE, 1, 1, 8'h00, SIZE - 1);
    chk("t4_ready", bus.frame_ready, 1);
    send_pix(1, 1, 1, 8'h00, -1);
    chk("t4_no_hold_col", wr_col, 1);

    // 5: reset mid-frame
    send_pix(199, 0, 1, 8'h00, -1);
    @(posedge clk);
    #2;
    reset = 1;
    model_reset();
    #1;
    check_zero("t5_reset");
    @(posedge clk);
    #2;
    reset = 0;
    send_pix(SIZE, 1, 1, 8'h00, -1);
    chk("t5_count", frame_count, 1);
    chk("t5_ready", bus.frame_ready, 1);

    // 6: frame sums (only observable with the stats feature)
    cyc(0, 0, 8'h00, 1, 0, '0);
    send_pix(SIZE, 1, 2, 8'h10, -1);
    cyc(0, 0, 8'h00, 1, 0, '0);
    send_pix(SIZE, 1, 2, 8'hFF, -1);
`ifdef GRAY_STATS_EN
    chk("t6_sum_ff", frame_sum, 24'(255 * SIZE));
`endif

    // random stress: aborted frames, missing sof, random releases
    rel_rate = 120;
    for (int k = 0; k < 40; k++) begin
      int len;
      len = (($urandom % 5) == 0) ? int'($urandom_range(1, SIZE - 1)) : SIZE;
      send_pix(len, ($urandom % 10) != 0, 1, 8'h00, -1);
      repeat ($urandom_range(0, 4)) step(0, 0, 8'h00, ($urandom % 3) == 0);
    end
    rel_rate = 0;

    bus.pix_valid = 0; bus.rd_en = 0; bus.frame_release = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
